// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO pop-side controller: state encoding,
// FIFO read latency and the skid depth that latency implies.
package fifo_reader_pkg;

  localparam int DATA_W_DEF  = 12;
  localparam int FIFO_RD_LAT = 1;
  // One slot per word that can be in flight plus one to keep streaming under ready.
  localparam int SKID_DEPTH  = FIFO_RD_LAT + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_reader_skid_buf2.sv
// Two-entry in-order buffer that absorbs FIFO read data; the head entry is
// driven straight out as registered data with a registered valid flag.
module skid_buf2
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] tail;

  // NOTE: sequential state uses non-blocking assignments so every register in
  // this block samples pre-edge values, which the head/tail shift relies on.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: both storage entries are reset (not just the count) because
      // the head is the visible data_out, which must read zero after reset.
      rd_data   <= '0;
      tail      <= '0;
      rd_valid  <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      unique case ({wr, rd})
        2'b10: begin
          if (occupancy == 2'd0) rd_data <= wr_data;
          else                   tail    <= wr_data;
          occupancy <= occupancy + 2'd1;
          rd_valid  <= 1'b1;
        end
        2'b01: begin
          if (occupancy == 2'd2) rd_data <= tail;
          occupancy <= occupancy - 2'd1;
          rd_valid  <= (occupancy == 2'd2);
        end
        2'b11: begin
          // Capture and consume together: count holds, the queue advances.
          if (occupancy == 2'd2) begin
            rd_data <= tail;
            tail    <= wr_data;
          end else begin
            rd_data <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Pop-side controller for the 12-bit transaction FIFO: issues pops against the
// 1-cycle read latency, streams words downstream and counts deliveries.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data_out,
  output logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic [CNT_W-1:0]  words_read,
  output logic              busy
);

  state_t     state;
  logic       inflight;
  logic [1:0] occupancy;
  logic       xfer;
  logic [2:0] fill_next;

  assign xfer = data_out_valid && data_out_ready;

  // Words the buffer will hold next cycle if no new pop is issued now.
  assign fill_next = 3'(occupancy) + 3'(inflight) - 3'(xfer);

  assign pop = (state == ACTIVE) && enable && !fifo_empty && !reset &&
               (fill_next < 3'(SKID_DEPTH));

  skid_buf2 #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .wr        (inflight),
    .wr_data   (fifo_data_out),
    .rd        (xfer),
    .rd_data   (data_out),
    .rd_valid  (data_out_valid),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      inflight   <= 1'b0;
      words_read <= '0;
    end else begin
      inflight <= pop;
      if (xfer) words_read <= words_read + CNT_W'(1);

      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= ACTIVE;
            busy  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!enable) begin
            if (inflight || occupancy != 2'd0) begin
              state <= DRAIN;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // A word still in flight lands in the buffer before we may go idle.
          if (enable) begin
            state <= ACTIVE;
          end else if (!inflight && occupancy == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a FIFO model feeds the DUT, the stimulus
// queues expected words and status, and a negedge monitor compares them.
module tb_fifo_reader;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 16;
  localparam int SB_SZ  = 64;

  typedef enum {K_POP, K_VALID, K_BUSY, K_WORDS, K_DATA, K_POPCNT, K_PENDING} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] val;
  } st_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_data_out = '0;
  logic              data_out_ready = 1'b0;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic [CNT_W-1:0]  words_read;
  logic              busy;

  logic              push = 1'b0;
  logic [DATA_W-1:0] push_word = '0;
  logic [DATA_W-1:0] fifo_q[$];

  logic [DATA_W-1:0] exp_mem[SB_SZ];
  int                exp_wr = 0;
  int                exp_rd = 0;
  st_t               st_mem[SB_SZ];
  int                st_wr = 0;
  int                st_rd = 0;

  int vectors = 0;
  int miscompares = 0;
  int pop_cnt = 0;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_data_out  (fifo_data_out),
    .pop            (pop),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .words_read     (words_read),
    .busy           (busy)
  );

  // FIFO with registered push and 1-cycle registered read data.
  always @(posedge clk) begin
    if (reset) begin
      fifo_q.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (pop && fifo_q.size() > 0) fifo_data_out <= fifo_q.pop_front();
      if (push) fifo_q.push_back(push_word);
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: queued status expectations first, then the delivered-word stream.
  always @(negedge clk) begin
    st_t         r;
    logic [31:0] act;
    while (st_rd != st_wr) begin
      r = st_mem[st_rd % SB_SZ];
      case (r.kind)
        K_POP:     act = 32'(pop);
        K_VALID:   act = 32'(data_out_valid);
        K_BUSY:    act = 32'(busy);
        K_WORDS:   act = 32'(words_read);
        K_DATA:    act = 32'(data_out);
        K_POPCNT:  act = 32'(pop_cnt);
        default:   act = 32'(exp_wr - exp_rd);
      endcase
      check(r.kind.name(), act, r.val);
      st_rd++;
    end
    if (reset) begin
      exp_rd = exp_wr;
    end else begin
      if (pop) pop_cnt++;
      if (pop && fifo_empty) check("pop_while_empty", 32'(pop), 32'd0);
      if (data_out_valid) begin
        if (exp_rd == exp_wr) begin
          check("spurious_valid", 32'(data_out_valid), 32'd0);
        end else begin
          check(data_out_ready ? "word" : "hold", 32'(data_out),
                32'(exp_mem[exp_rd % SB_SZ]));
          if (data_out_ready) exp_rd++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input kind_t k, input logic [31:0] v);
    st_mem[st_wr % SB_SZ] = '{kind: k, val: v};
    st_wr++;
  endtask

  task automatic push_fifo(input logic [DATA_W-1:0] w);
    push      = 1'b1;
    push_word = w;
    exp_mem[exp_wr % SB_SZ] = w;
    exp_wr++;
    tick();
    push = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_rd == exp_wr && !data_out_valid) break;
      tick();
    end
    expect_st(K_PENDING, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;

    // Reset held for 3 clocks.
    repeat (3) tick();
    expect_st(K_POP, 0);
    expect_st(K_VALID, 0);
    expect_st(K_WORDS, 0);
    expect_st(K_BUSY, 0);
    tick();
    reset = 1'b0;
    tick();

    // Streaming with ready held high.
    push_fifo(12'h00A);
    push_fifo(12'h00B);
    base = pop_cnt;
    data_out_ready = 1'b1;
    enable = 1'b1;
    repeat (3) tick();
    expect_st(K_VALID, 1);
    expect_st(K_DATA, 32'h00A);
    tick();
    expect_st(K_VALID, 1);
    expect_st(K_DATA, 32'h00B);
    tick();
    expect_st(K_VALID, 0);
    expect_st(K_WORDS, 2);
    expect_st(K_POPCNT, 32'(base + 2));
    enable = 1'b0;
    repeat (2) tick();
    expect_st(K_BUSY, 0);
    expect_st(K_POP, 0);

    // Backpressure: only two pops fit while ready is low.
    data_out_ready = 1'b0;
    push_fifo(12'h00C);
    push_fifo(12'h00D);
    push_fifo(12'h00E);
    base = pop_cnt;
    enable = 1'b1;
    repeat (8) tick();
    expect_st(K_POPCNT, 32'(base + 2));
    expect_st(K_VALID, 1);
    expect_st(K_DATA, 32'h00C);
    data_out_ready = 1'b1;
    wait_drain(30);
    expect_st(K_WORDS, 5);
    enable = 1'b0;
    repeat (2) tick();
    expect_st(K_BUSY, 0);

    // Enable dropped the cycle after a pop: the in-flight word drains out.
    data_out_ready = 1'b0;
    push_fifo(12'h010);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (pop) break;
      tick();
    end
    expect_st(K_POP, 1);
    tick();
    enable = 1'b0;
    tick();
    expect_st(K_BUSY, 1);
    expect_st(K_VALID, 1);
    repeat (2) tick();
    expect_st(K_BUSY, 1);
    data_out_ready = 1'b1;
    wait_drain(20);
    repeat (2) tick();
    expect_st(K_BUSY, 0);
    expect_st(K_WORDS, 6);

    // Empty FIFO gates pop; a push releases it the cycle empty falls.
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_st(K_POP, 0);
    end
    push_fifo(12'h00F);
    expect_st(K_POP, 1);
    expect_st(K_VALID, 0);
    tick();
    expect_st(K_VALID, 0);
    tick();
    expect_st(K_VALID, 1);
    expect_st(K_DATA, 32'h00F);
    tick();
    wait_drain(20);
    expect_st(K_WORDS, 7);
    enable = 1'b0;
    repeat (2) tick();

    // Reset with a full buffer under backpressure.
    data_out_ready = 1'b0;
    push_fifo(12'h021);
    push_fifo(12'h022);
    push_fifo(12'h023);
    enable = 1'b1;
    repeat (6) tick();
    expect_st(K_VALID, 1);
    expect_st(K_DATA, 32'h021);
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    reset = 1'b0;
    expect_st(K_VALID, 0);
    expect_st(K_DATA, 0);
    expect_st(K_WORDS, 0);
    expect_st(K_BUSY, 0);
    expect_st(K_POP, 0);
    enable = 1'b1;
    data_out_ready = 1'b1;
    push_fifo(12'h123);
    wait_drain(20);
    expect_st(K_WORDS, 1);
    enable = 1'b0;
    repeat (2) tick();
    expect_st(K_BUSY, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
